// File: rtl/hc595_chain_driver.sv
// Serial driver for a cascade of 74HC595 shift registers: accepts a parallel word,
// shifts it out on ds/shcp with a programmable divider, then pulses stcp to latch it.
module hc595_chain_driver #(
    parameter int N_CHIPS   = 2,
    parameter int CLK_DIV   = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*N_CHIPS-1:0]   data,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic                   blank,
    output logic                   busy,
    output logic                   done,
    output logic                   ds,
    output logic                   shcp,
    output logic                   stcp,
    output logic                   oe
);

    localparam int W     = 8 * N_CHIPS;
    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);
    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    state_t           state, state_nx;
    logic [W-1:0]     shreg, shreg_nx;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nx;
    logic [7:0]       div_cnt, div_cnt_nx;
    logic             ds_nx, shcp_nx, stcp_nx, busy_nx, ready_nx, done_nx;
    logic             accept, div_end, shifting_nx;

    function automatic logic out_bit(input logic [W-1:0] w);
        return (MSB_FIRST != 0) ? w[W-1] : w[0];
    endfunction

    assign accept  = load_valid && load_ready;
    assign div_end = (div_cnt == DIV_LAST);

    // NOTE: every signal written here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bit_cnt_nx = bit_cnt;
        div_cnt_nx = div_cnt;

        case (state)
            IDLE: begin
                div_cnt_nx = '0;
                if (accept) begin
                    shreg_nx   = data;
                    bit_cnt_nx = '0;
                    state_nx   = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_end) begin
                    div_cnt_nx = '0;
                    state_nx   = SHIFT_HI;
                end else begin
                    div_cnt_nx = div_cnt + 8'd1;
                end
            end
            SHIFT_HI: begin
                if (div_end) begin
                    div_cnt_nx = '0;
                    if (bit_cnt == LAST_BIT) begin
                        state_nx = LATCH;
                    end else begin
                        shreg_nx   = (MSB_FIRST != 0) ? {shreg[W-2:0], 1'b0}
                                                      : {1'b0, shreg[W-1:1]};
                        bit_cnt_nx = bit_cnt + 1'b1;
                        state_nx   = SHIFT_LO;
                    end
                end else begin
                    div_cnt_nx = div_cnt + 8'd1;
                end
            end
            LATCH: begin
                if (div_end) begin
                    div_cnt_nx = '0;
                    state_nx   = IDLE;
                end else begin
                    div_cnt_nx = div_cnt + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Outputs are decoded from the next state so the pins come straight off flops.
        shifting_nx = (state_nx == SHIFT_LO) || (state_nx == SHIFT_HI);
        ds_nx       = shifting_nx ? out_bit(shreg_nx) : 1'b0;
        shcp_nx     = (state_nx == SHIFT_HI);
        stcp_nx     = (state_nx == LATCH);
        busy_nx     = (state_nx != IDLE);
        ready_nx    = (state_nx == IDLE);
        done_nx     = (state == LATCH) && (state_nx == IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            ds         <= 1'b0;
            shcp       <= 1'b0;
            stcp       <= 1'b0;
            busy       <= 1'b0;
            load_ready <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            shreg      <= shreg_nx;
            bit_cnt    <= bit_cnt_nx;
            div_cnt    <= div_cnt_nx;
            ds         <= ds_nx;
            shcp       <= shcp_nx;
            stcp       <= stcp_nx;
            busy       <= busy_nx;
            load_ready <= ready_nx;
            done       <= done_nx;
        end
    end

    // Blanking path is deliberately separate from the transfer FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oe <= 1'b1;
        end else begin
            oe <= blank;
        end
    end

endmodule

// File: doc/hc595_chain_driver.md
# hc595_chain_driver

Parametrised serial driver for a cascade of N_CHIPS 74HC595 shift registers, generalising the single-pair segment/select serialiser used by the digit display path. It accepts a parallel word over a valid/ready handshake and shifts it out on ds/shcp with a programmable shift-clock divider and selectable bit order. It then pulses stcp to latch the word into the chips' storage registers. A separate blank input drives oe, so the display path (number generator -> segment encoder -> this block) can dim or blank the outputs without re-sending data.

## Interface
- N_CHIPS, 2: number of cascaded 74HC595; word width W = 8*N_CHIPS.
- CLK_DIV, 2: system clocks per shcp half-period, and the stcp high time; legal range 1..255.
- MSB_FIRST, 1: 1 shifts data[W-1] first; 0 shifts data[0] first.

- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- data  in  W  parallel word; sampled only on an accepted load.
- load_valid  in  1  request to send data.
- load_ready  out  1  block is idle and can accept a load.
- blank  in  1  1 = outputs disabled (oe high).
- busy  out  1  transfer in progress (shift or latch phase).
- done  out  1  one-cycle pulse when stcp completes.
- ds  out  1  serial data to the first chip.
- shcp  out  1  shift clock; the chip shifts on its rising edge.
- stcp  out  1  storage latch clock; the chip latches on its rising edge.
- oe  out  1  output enable, active-low.

## Operation
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE
  - load_ready=1, busy=0, shcp=0, stcp=0.
  - On load_valid && load_ready: capture data into a W-bit shift register, set bit_cnt=0 and div_cnt=0, then go to SHIFT_LO.
- SHIFT_LO
  - shcp=0; ds = current bit (shreg[W-1] if MSB_FIRST, else shreg[0]).
  - After CLK_DIV cycles, go to SHIFT_HI.
- SHIFT_HI
  - shcp=1; ds unchanged.
  - After CLK_DIV cycles:
    - If bit_cnt==W-1, go to LATCH.
    - Otherwise shift shreg by one toward the output end, increment bit_cnt, and go to SHIFT_LO.
- LATCH
  - shcp=0, stcp=1, ds=0.
  - After CLK_DIV cycles, go to IDLE and assert done for exactly that first IDLE cycle.
- busy=1 in SHIFT_LO, SHIFT_HI and LATCH; load_ready = !busy.
- load_valid while busy is ignored; no queueing.
- Final chip contents:
  - MSB_FIRST=1: data[7:0] in the chip nearest ds, data[W-1:W-8] in the last chip.
  - MSB_FIRST=0: the order is reversed.
- oe = registered blank, one-cycle latency, independent of the FSM; blank never stalls or corrupts a transfer.
- Widths:
  - bit_cnt is $clog2(W) bits.
  - div_cnt is 8 bits; it counts 0..CLK_DIV-1, then wraps to 0 on each state change.

## Timing
- All outputs are registered; there is no combinational path from inputs to ds, shcp, stcp or oe.
- Reset values: ds=0, shcp=0, stcp=0, oe=1, busy=0, done=0, load_ready=0 while rst is high. load_ready becomes 1 on the first clock after rst is released.
- Transfer timing, with the accept edge taken as cycle 0:
  - busy is high in cycles 1 .. (2W+1)*CLK_DIV.
  - done and load_ready are high in cycle (2W+1)*CLK_DIV + 1.
- Back-to-back: a load accepted in the done cycle starts SHIFT_LO on the next cycle, with no extra idle cycles.
- ds timing: ds changes only on entry to SHIFT_LO. This gives CLK_DIV cycles of setup and CLK_DIV cycles of hold around each shcp rising edge.
- shcp rising edges: exactly W per transfer.
- stcp: exactly one pulse per transfer, starting CLK_DIV cycles after the final shcp rising edge.
- Reset mid-transfer:
  - The FSM returns to IDLE immediately and all outputs take their reset values.
  - stcp is not pulsed, so the chips' storage registers keep the previous word.
  - done does not assert.
- Simultaneous load and blank change: both take effect; the two paths are independent.

## Test plan
All scenarios use N_CHIPS=2 and CLK_DIV=2 unless stated otherwise.
- Reset hold -> ds=0, shcp=0, stcp=0, oe=1, busy=0, done=0, load_ready=0; load_ready=1 one cycle after rst falls.
- Load 16'hA55A with MSB_FIRST=1 -> ds sampled at the 16 shcp rising edges = 1010010101011010; one stcp pulse 2 cycles wide; busy high for 66 cycles; done at cycle 67.
- MSB_FIRST=0 with 16'h0001 -> first sampled ds bit = 1, the remaining 15 bits = 0.
- load_valid held high with 16'h1234 then 16'h5678 -> second word accepted in the done cycle of the first; its first SHIFT_LO starts the next cycle; two stcp pulses total.
- load_valid pulsed at cycle 20 of an active transfer -> ignored; exactly 16 shcp rising edges and one stcp pulse.
- rst asserted after 5 shcp rising edges -> outputs reset within the same cycle; no stcp pulse and no done. Separately, toggling blank mid-transfer -> oe follows one cycle later and the ds/shcp sequence is unchanged.
